gb_lcd_scaler: RTL and testbench

GB_LCD_SCALER -- requirements
Module: gb_lcd_scaler

---
 rtl/gb_video_pkg.sv | 33 +++
 rtl/gb_frame_ram.sv | 35 +++
 rtl/gb_lcd_scaler.sv | 217 +++++++++++++++++++++
 tb/tb_gb_lcd_scaler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gb_video_pkg.sv
// gb_video_pkg
//   Shared Game Boy video constants: LCD geometry, frame buffer size and
//   address width, the four DMG palette colours, the horizontal scaler
//   state encoding, and a shade-to-RGB helper.
package gb_video_pkg;

  localparam int GB_W      = 160;
  localparam int GB_H      = 144;
  localparam int FRAME_PIX = GB_W * GB_H;  // 23040
  localparam int FRAME_AW  = 15;

  localparam logic [23:0] PAL_0 = 24'h9BBC0F;
  localparam logic [23:0] PAL_1 = 24'h8BAC0F;
  localparam logic [23:0] PAL_2 = 24'h306230;
  localparam logic [23:0] PAL_3 = 24'h0F380F;

  typedef enum logic [1:0] {
    H_BLANK = 2'd0,
    H_LEFT  = 2'd1,
    H_WIN   = 2'd2,
    H_RIGHT = 2'd3
  } hstate_t;

  function automatic logic [23:0] shade_to_rgb(input logic [1:0] shade);
    case (shade)
      2'd0:    return PAL_0;
      2'd1:    return PAL_1;
      2'd2:    return PAL_2;
      default: return PAL_3;
    endcase
  endfunction

endpackage

// File: rtl/gb_frame_ram.sv
// gb_frame_ram
//   Simple dual-port frame buffer, FRAME_PIX x 2 bits, single clock.
//   Ports:
//     i_clk                 clock
//     i_we/i_wr_addr/i_wr_data   write port
//     i_rd_en/i_rd_addr     synchronous read request
//     o_rd_data             read data, valid the cycle after i_rd_en
//   A read and a write to the same address in one cycle returns the old
//   contents (the read samples the array before the write lands).
//   Contents are not reset.
module gb_frame_ram
  import gb_video_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_we,
  input  logic [FRAME_AW-1:0] i_wr_addr,
  input  logic [1:0]          i_wr_data,
  input  logic                i_rd_en,
  input  logic [FRAME_AW-1:0] i_rd_addr,
  output logic [1:0]          o_rd_data
);

  logic [1:0] r_mem [0:FRAME_PIX-1];
  logic [1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_we)
      r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en)
      r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/gb_lcd_scaler.sv
// gb_lcd_scaler
//   Stores Game Boy PPU pixels in a frame buffer and scans them out as an
//   integer-upscaled window inside a larger raster (e.g. 640x480).
//   Ports:
//     fbclk, fbclk_rst          clock, synchronous active-high reset
//     pix_valid/pix_sof/pix_data  PPU pixel stream (write side)
//     wr_frame_done             pulse after frame pixel 23039 is written
//     hs_i/vs_i/border_i        raw raster timing (hs/vs active-low,
//                               border_i=1 means blanking)
//     hs_o/vs_o/border_o        timing delayed by 2 cycles
//     red/green/blue            colour aligned with border_o
//     o_dbg_hstate              horizontal FSM state, for observation
//   Pixel handshake: pix_valid alone qualifies a pixel; there is no ready,
//   so every cycle with pix_valid=1 writes exactly one pixel.
//   Read pipeline: cycle N decides window/address, N+1 RAM data, N+2
//   palette-mapped colour, matching the 2-stage delay on the timing signals.
module gb_lcd_scaler
  import gb_video_pkg::*;
#(
  parameter int          SCALE      = 3,
  parameter int          X_OFF      = 80,
  parameter int          Y_OFF      = 24,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic       fbclk,
  input  logic       fbclk_rst,
  input  logic       pix_valid,
  input  logic       pix_sof,
  input  logic [1:0] pix_data,
  output logic       wr_frame_done,
  input  logic       hs_i,
  input  logic       vs_i,
  input  logic       border_i,
  output logic       hs_o,
  output logic       vs_o,
  output logic       border_o,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [1:0] o_dbg_hstate
);

  localparam logic [9:0]          X_OFF_L   = 10'(X_OFF);
  localparam logic [9:0]          Y_OFF_L   = 10'(Y_OFF);
  localparam logic [9:0]          Y_END_L   = 10'(Y_OFF + GB_H * SCALE);
  localparam logic [7:0]          SUB_MAX   = 8'(SCALE - 1);
  localparam logic [7:0]          GB_W_L    = 8'(GB_W);
  localparam logic [7:0]          GB_H_L    = 8'(GB_H);
  localparam logic [FRAME_AW-1:0] LINE_STEP = FRAME_AW'(GB_W);
  localparam logic [FRAME_AW-1:0] LAST_ADDR = FRAME_AW'(FRAME_PIX - 1);

  // ---------------- write side ----------------
  logic [FRAME_AW-1:0] r_wr_addr;
  logic                r_frame_done;
  logic [FRAME_AW-1:0] w_wr_addr;

  assign w_wr_addr = (pix_valid && pix_sof) ? '0 : r_wr_addr;

  always_ff @(posedge fbclk) begin
    if (fbclk_rst) begin
      r_wr_addr    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= pix_valid && (w_wr_addr == LAST_ADDR);
      if (pix_valid)
        r_wr_addr <= (w_wr_addr == LAST_ADDR) ? '0 : w_wr_addr + 1'b1;
    end
  end

  assign wr_frame_done = r_frame_done;

  // ---------------- horizontal tracking ----------------
  // r_ax is the column index of the pixel currently on border_i=0.
  logic [9:0] r_ax;
  logic       r_bd_q;
  hstate_t    r_hstate;
  logic [7:0] r_gx;
  logic [7:0] r_sx;
  logic       w_enter;
  logic       w_pix_win;
  logic [7:0] w_gx;
  logic [7:0] w_sx;

  // The first window pixel is recognised combinationally so the RAM read
  // for it can be issued in the same cycle; gb_x/sub-counter read as zero
  // on that cycle regardless of their stale register values.
  assign w_enter   = !border_i && (r_ax == X_OFF_L) &&
                     ((r_hstate == H_LEFT) || (r_hstate == H_BLANK && r_bd_q));
  assign w_pix_win = w_enter ||
                     (!border_i && (r_hstate == H_WIN) && (r_gx != GB_W_L));
  assign w_gx      = w_enter ? '0 : r_gx;
  assign w_sx      = w_enter ? '0 : r_sx;

  always_ff @(posedge fbclk) begin
    if (fbclk_rst) begin
      r_ax     <= '0;
      r_bd_q   <= 1'b1;
      r_hstate <= H_BLANK;
      r_gx     <= '0;
      r_sx     <= '0;
    end else begin
      r_bd_q <= border_i;
      r_ax   <= border_i ? '0 : r_ax + 10'd1;
      if (w_pix_win) begin
        if (w_sx == SUB_MAX) begin
          r_sx <= '0;
          r_gx <= w_gx + 8'd1;
        end else begin
          r_sx <= w_sx + 8'd1;
          r_gx <= w_gx;
        end
      end
      if (border_i) begin
        r_hstate <= H_BLANK;
      end else begin
        case (r_hstate)
          H_BLANK: if (r_bd_q) r_hstate <= (r_ax == X_OFF_L) ? H_WIN : H_LEFT;
          H_LEFT:  if (r_ax == X_OFF_L) r_hstate <= H_WIN;
          // gb_x reaching 160 means 160*SCALE window pixels have been shown
          H_WIN:   if (r_gx == GB_W_L) r_hstate <= H_RIGHT;
          default: r_hstate <= r_hstate;
        endcase
      end
    end
  end

  assign o_dbg_hstate = r_hstate;

  // ---------------- vertical tracking ----------------
  logic [9:0]          r_ay;
  logic [7:0]          r_gy;
  logic [7:0]          r_sy;
  logic [FRAME_AW-1:0] r_line_base;
  logic                w_line_win;

  // The gb_y bound is redundant with the ay range for sane parameters but
  // keeps a mis-sized raster from reading past the frame buffer.
  assign w_line_win = (r_ay >= Y_OFF_L) && (r_ay < Y_END_L) && (r_gy < GB_H_L);

  always_ff @(posedge fbclk) begin
    if (fbclk_rst || !vs_i) begin
      r_ay        <= '0;
      r_gy        <= '0;
      r_sy        <= '0;
      r_line_base <= '0;
    end else if (border_i && !r_bd_q) begin
      r_ay <= r_ay + 10'd1;
      if (w_line_win) begin
        if (r_sy == SUB_MAX) begin
          r_sy        <= '0;
          r_gy        <= r_gy + 8'd1;
          r_line_base <= r_line_base + LINE_STEP;
        end else begin
          r_sy <= r_sy + 8'd1;
        end
      end
    end
  end

  // ---------------- frame buffer ----------------
  logic                w_rd_en;
  logic [FRAME_AW-1:0] w_rd_addr;
  logic [1:0]          w_rd_data;

  assign w_rd_en   = w_pix_win && w_line_win;
  assign w_rd_addr = r_line_base + {7'd0, w_gx};

  gb_frame_ram u_ram (
    .i_clk     (fbclk),
    .i_we      (pix_valid),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (pix_data),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  // ---------------- output pipeline ----------------
  logic        r_hs1, r_vs1, r_bd1, r_win1;
  logic        r_hs2, r_vs2, r_bd2;
  logic [23:0] r_rgb;

  always_ff @(posedge fbclk) begin
    if (fbclk_rst) begin
      r_hs1  <= 1'b1;
      r_vs1  <= 1'b1;
      r_bd1  <= 1'b1;
      r_win1 <= 1'b0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_bd2  <= 1'b1;
      r_rgb  <= '0;
    end else begin
      r_hs1  <= hs_i;
      r_vs1  <= vs_i;
      r_bd1  <= border_i;
      r_win1 <= w_rd_en;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_bd2  <= r_bd1;
      if (r_bd1)
        r_rgb <= '0;
      else if (r_win1)
        r_rgb <= shade_to_rgb(w_rd_data);
      else
        r_rgb <= BORDER_RGB;
    end
  end

  assign hs_o     = r_hs2;
  assign vs_o     = r_vs2;
  assign border_o = r_bd2;
  assign red      = r_rgb[23:16];
  assign green    = r_rgb[15:8];
  assign blue     = r_rgb[7:0];

endmodule

// File: tb/tb_gb_lcd_scaler.sv
module tb_gb_lcd_scaler;

  localparam logic [23:0] BRD = 24'h203040;
  localparam logic [23:0] C0  = 24'h9BBC0F;
  localparam logic [23:0] C1  = 24'h8BAC0F;
  localparam logic [23:0] C2  = 24'h306230;
  localparam logic [23:0] C3  = 24'h0F380F;

  // ---------------- clock / reset / DUT ----------------
  logic       fbclk = 1'b0;
  logic       fbclk_rst;
  logic       pix_valid, pix_sof;
  logic [1:0] pix_data;
  logic       wr_frame_done;
  logic       hs_i, vs_i, border_i;
  logic       hs_o, vs_o, border_o;
  logic [7:0] red, green, blue;
  logic [1:0] dbg_hstate;

  always #5 fbclk = ~fbclk;

  gb_lcd_scaler #(
    .SCALE(3), .X_OFF(80), .Y_OFF(24), .BORDER_RGB(BRD)
  ) dut (
    .fbclk         (fbclk),
    .fbclk_rst     (fbclk_rst),
    .pix_valid     (pix_valid),
    .pix_sof       (pix_sof),
    .pix_data      (pix_data),
    .wr_frame_done (wr_frame_done),
    .hs_i          (hs_i),
    .vs_i          (vs_i),
    .border_i      (border_i),
    .hs_o          (hs_o),
    .vs_o          (vs_o),
    .border_o      (border_o),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .o_dbg_hstate  (dbg_hstate)
  );

  int cyc = 0;
  always @(posedge fbclk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_done = 0;
  int          out_col = 0;
  int          t_bdi_fall = 0, t_bdo_fall = 0, t_hsi_fall = 0, t_hso_fall = 0;
  logic        prev_bd_o = 1'b1, prev_hs_o = 1'b1;
  logic [23:0] cap [0:639];
  logic [23:0] exp_q[$];
  int          col_q[$];

  // Output monitor: captures one active line of colour by output column.
  always @(negedge fbclk) begin
    if (!border_o) begin
      if (out_col < 640) cap[out_col] = {red, green, blue};
      out_col = out_col + 1;
    end else begin
      out_col = 0;
    end
    if (prev_bd_o && !border_o) t_bdo_fall = cyc;
    if (prev_hs_o && !hs_o)     t_hso_fall = cyc;
    if (wr_frame_done)          n_done = n_done + 1;
    prev_bd_o = border_o;
    prev_hs_o = hs_o;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge fbclk);
    #1;
  endtask

  task automatic write_pix(input logic sof, input logic [1:0] shade);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = shade;
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic check_reset_outputs(input string where);
    check_val($sformatf("%s_red", where),      32'(red),           32'h0);
    check_val($sformatf("%s_green", where),    32'(green),         32'h0);
    check_val($sformatf("%s_blue", where),     32'(blue),          32'h0);
    check_val($sformatf("%s_border_o", where), 32'(border_o),      32'h1);
    check_val($sformatf("%s_hs_o", where),     32'(hs_o),          32'h1);
    check_val($sformatf("%s_vs_o", where),     32'(vs_o),          32'h1);
    check_val($sformatf("%s_done", where),     32'(wr_frame_done), 32'h0);
  endtask

  task automatic drive_vblank();
    border_i = 1'b1;
    hs_i     = 1'b1;
    vs_i     = 1'b0;
    repeat (4) tick();
    vs_i = 1'b1;
    repeat (4) tick();
  endtask

  // One raster line: act active cycles then blk blanking cycles; hsync is
  // pulsed inside long blanking. rst_col >= 0 pulses reset at that column.
  task automatic drive_line(input int act, input int blk, input int rst_col);
    for (int c = 0; c < act; c++) begin
      if (c == 0) t_bdi_fall = cyc;
      border_i = 1'b0;
      if (c == rst_col) begin
        check_val("state_win_before_rst", 32'(dbg_hstate), 32'd2);
        fbclk_rst = 1'b1;
      end
      tick();
      if (c == rst_col) begin
        fbclk_rst = 1'b0;
        check_reset_outputs("rst_midline");
      end
    end
    border_i = 1'b1;
    for (int b = 0; b < blk; b++) begin
      hs_i = (blk >= 8 && b >= 2 && b < 5) ? 1'b0 : 1'b1;
      if (blk >= 8 && b == 2) t_hsi_fall = cyc;
      tick();
    end
    hs_i = 1'b1;
  endtask

  task automatic expect_px(input int col, input logic [23:0] rgb);
    col_q.push_back(col);
    exp_q.push_back(rgb);
  endtask

  // Hand-computed expectations per pass/line. Pass 1 frame: shade=(x+y)&3.
  task automatic check_line(input int pass, input int ln);
    int          c;
    logic [23:0] e;
    if (pass == 1) begin
      case (ln)
        0:   begin expect_px(0, BRD); expect_px(80, BRD); expect_px(320, BRD); expect_px(639, BRD); end
        23:  begin expect_px(80, BRD); expect_px(300, BRD); end
        24:  begin
               expect_px(0, BRD);  expect_px(79, BRD);
               expect_px(80, C0);  expect_px(81, C0);  expect_px(82, C0);
               expect_px(83, C1);  expect_px(84, C1);  expect_px(85, C1);
               expect_px(86, C2);  expect_px(89, C3);  expect_px(92, C0);
               expect_px(559, C3); expect_px(560, BRD); expect_px(639, BRD);
               check_val("border_o_align", 32'(t_bdo_fall - t_bdi_fall), 32'd2);
               check_val("hs_o_align",     32'(t_hso_fall - t_hsi_fall), 32'd2);
             end
        26:  begin expect_px(80, C0); expect_px(83, C1); end
        27:  begin expect_px(80, C1); expect_px(82, C1); expect_px(83, C2); end
        455: begin expect_px(80, C3); expect_px(83, C0); expect_px(559, C2); end
        456: begin expect_px(80, BRD); expect_px(300, BRD); end
        479: begin expect_px(80, BRD); end
        default: ;
      endcase
    end else if (pass == 2) begin
      // row 0 now: gx0=3 (SOF), gx1=0, gx2..99=1, gx100+ = gx&3
      expect_px(80, C3);  expect_px(82, C3);  expect_px(83, C0);
      expect_px(86, C1);  expect_px(95, C1);  expect_px(377, C1);
      expect_px(380, C0); expect_px(383, C1);
    end else begin
      // after reset, the next write lands at address 0
      expect_px(80, C2); expect_px(83, C0); expect_px(86, C1);
    end
    while (exp_q.size() > 0) begin
      c = col_q.pop_front();
      e = exp_q.pop_front();
      check_val($sformatf("p%0d_line%0d_col%0d", pass, ln, c), 32'(cap[c]), 32'(e));
    end
  endtask

  task automatic display_frame(input int pass, input int n_lines);
    logic full;
    drive_vblank();
    for (int ln = 0; ln < n_lines; ln++) begin
      if (pass == 1)
        full = (ln == 0 || ln == 23 || ln == 24 || ln == 26 || ln == 27 ||
                ln == 455 || ln == 456 || ln == 479);
      else
        full = (ln == 24);
      if (full) begin
        drive_line(640, 8, (pass == 3) ? 200 : -1);
        if (pass != 3) check_line(pass, ln);
      end else begin
        drive_line(4, 2, -1);
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    fbclk_rst = 1'b1;
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_data  = 2'd0;
    hs_i      = 1'b1;
    vs_i      = 1'b1;
    border_i  = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    fbclk_rst = 1'b0;
    repeat (2) tick();

    // fill the frame, SOF on the first pixel
    for (int y = 0; y < 144; y++) begin
      for (int x = 0; x < 160; x++) begin
        if (y == 143 && x == 159) check_val("done_before_last", 32'(wr_frame_done), 32'h0);
        write_pix((y == 0 && x == 0), 2'((x + y) % 4));
      end
    end
    check_val("done_pulse", 32'(wr_frame_done), 32'h1);
    tick();
    check_val("done_one_cycle", 32'(wr_frame_done), 32'h0);
    check_val("done_count", 32'(n_done), 32'd1);

    display_frame(1, 480);

    // wrap to address 0, then mid-frame SOF after 100 pixels
    repeat (100) write_pix(1'b0, 2'd1);
    write_pix(1'b1, 2'd3);
    write_pix(1'b0, 2'd0);
    tick();
    check_val("done_count_after_wrap", 32'(n_done), 32'd1);
    display_frame(2, 25);

    // reset pulse in the middle of a window line
    display_frame(3, 25);
    write_pix(1'b0, 2'd2);
    tick();
    display_frame(4, 25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
